mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 7 +
 rtl/addr_xlate.sv | 9 +
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and constants for the memory arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, INST, DATA, DONE} state_e;
  localparam logic [1:0] INST_SIZE = 2'b10;
  localparam logic [3:0] INST_SEL = 4'b1111;
  localparam logic [31:0] KSEG_MASK = 32'h1fff_ffff;
endpackage

// File: rtl/addr_xlate.sv
// addr_xlate: kseg0/kseg1 virtual-to-physical translation (upper three bits stripped when bit 31 set).
module addr_xlate
  import mem_arb_pkg::*;
(
  input  logic [31:0] vaddr_i,
  output logic [31:0] paddr_o
);
  assign paddr_o = vaddr_i[31] ? (vaddr_i & KSEG_MASK) : vaddr_i;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates instruction and data accesses onto one downstream memory port, data first.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_ready,
  input  logic        data_req,
  input  logic        data_write,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_ready,
  input  logic        flush,
  output logic        mem_access,
  output logic        mem_write,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_sel,
  output logic [31:0] mem_a,
  output logic [31:0] mem_st_data,
  input  logic        mem_ready,
  input  logic [31:0] mem_data,
  output logic        stall_if,
  output logic        stall_mem
);
  state_e state_q, state_d;
  logic data_side_q, data_side_d;
  logic write_q, write_d;
  logic [1:0] size_q, size_d;
  logic [3:0] sel_q, sel_d;
  logic [31:0] a_q, a_d, st_data_q, st_data_d;
  logic [31:0] inst_rdata_q, inst_rdata_d, data_rdata_q, data_rdata_d;
  logic [31:0] inst_pa, data_pa;
  logic done;

  addr_xlate u_inst_xlate (.vaddr_i(inst_addr), .paddr_o(inst_pa));
  addr_xlate u_data_xlate (.vaddr_i(data_addr), .paddr_o(data_pa));

  always_comb begin
    state_d = state_q;
    data_side_d = data_side_q;
    write_d = write_q;
    size_d = size_q;
    sel_d = sel_q;
    a_d = a_q;
    st_data_d = st_data_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (data_req) begin
            state_d = DATA;
            data_side_d = 1'b1;
            write_d = data_write;
            size_d = data_size;
            sel_d = data_wen;
            a_d = data_pa;
            st_data_d = data_wdata;
          end else if (inst_req) begin
            state_d = INST;
            data_side_d = 1'b0;
            write_d = 1'b0;
            size_d = INST_SIZE;
            sel_d = INST_SEL;
            a_d = inst_pa;
            st_data_d = '0;
          end
        end
        INST, DATA: begin
          if (mem_ready) begin
            state_d = DONE;
            // stores complete without touching the load data register
            if (state_q == INST) inst_rdata_d = mem_data;
            else if (!write_q) data_rdata_d = mem_data;
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q <= IDLE;
      data_side_q <= 1'b0;
      write_q <= 1'b0;
      size_q <= '0;
      sel_q <= '0;
      a_q <= '0;
      st_data_q <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      data_side_q <= data_side_d;
      write_q <= write_d;
      size_q <= size_d;
      sel_q <= sel_d;
      a_q <= a_d;
      st_data_q <= st_data_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign done = (state_q == DONE) && !flush;
  assign inst_ready = done && !data_side_q;
  assign data_ready = done && data_side_q;
  assign mem_access = (state_q == INST) || (state_q == DATA);
  assign mem_write = write_q;
  assign mem_size = size_q;
  assign mem_sel = sel_q;
  assign mem_a = a_q;
  assign mem_st_data = st_data_q;
  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;
  assign stall_if = inst_req & ~inst_ready;
  assign stall_mem = data_req & ~data_ready;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic inst_req = 1'b0, data_req = 1'b0, data_write = 1'b0, flush = 1'b0, mem_ready = 1'b0;
  logic [31:0] inst_addr = '0, data_addr = '0, data_wdata = '0, mem_data = '0;
  logic [1:0] data_size = '0;
  logic [3:0] data_wen = '0;
  logic [31:0] inst_rdata, data_rdata, mem_a, mem_st_data;
  logic inst_ready, data_ready, mem_access, mem_write, stall_if, stall_mem;
  logic [1:0] mem_size;
  logic [3:0] mem_sel;
  int checks = 0, errors = 0;
  logic cmp_en = 1'b0;

  mem_arbiter dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ready(inst_ready),
    .data_req(data_req), .data_write(data_write), .data_size(data_size), .data_wen(data_wen),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata), .data_ready(data_ready),
    .flush(flush), .mem_access(mem_access), .mem_write(mem_write), .mem_size(mem_size),
    .mem_sel(mem_sel), .mem_a(mem_a), .mem_st_data(mem_st_data),
    .mem_ready(mem_ready), .mem_data(mem_data), .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] phys(input logic [31:0] v);
    return v[31] ? v - 32'h8000_0000 - (v[30] ? 32'h4000_0000 : 0) - (v[29] ? 32'h2000_0000 : 0) : v;
  endfunction

  // transaction-level reference: one outstanding access, then a single completion slot
  logic m_busy, m_isdata, m_write;
  logic [1:0] m_pulse, m_size;
  logic [3:0] m_sel;
  logic [31:0] m_a, m_wd, m_ird, m_drd;

  always @(posedge clk or posedge resetn) begin
    if (resetn) begin
      m_busy <= 0; m_isdata <= 0; m_write <= 0; m_pulse <= 0; m_size <= 0;
      m_sel <= 0; m_a <= 0; m_wd <= 0; m_ird <= 0; m_drd <= 0;
    end else if (flush) begin
      m_busy <= 0; m_pulse <= 0;
    end else if (m_pulse != 0) begin
      m_pulse <= 0;
    end else if (m_busy) begin
      if (mem_ready) begin
        m_busy <= 0;
        m_pulse <= m_isdata ? 2'd2 : 2'd1;
        if (!m_isdata) m_ird <= mem_data;
        else if (!m_write) m_drd <= mem_data;
      end
    end else if (data_req) begin
      m_busy <= 1; m_isdata <= 1; m_write <= data_write; m_size <= data_size;
      m_sel <= data_wen; m_a <= phys(data_addr); m_wd <= data_wdata;
    end else if (inst_req) begin
      m_busy <= 1; m_isdata <= 0; m_write <= 0; m_size <= 2'b10;
      m_sel <= 4'hf; m_a <= phys(inst_addr); m_wd <= 0;
    end
  end

  logic e_ir, e_dr;
  always @(negedge clk) begin
    if (cmp_en) begin
      e_ir = (m_pulse == 2'd1) && !flush;
      e_dr = (m_pulse == 2'd2) && !flush;
      chk("mem_access", 32'(mem_access), 32'(m_busy));
      chk("mem_write", 32'(mem_write), 32'(m_write));
      chk("mem_size", 32'(mem_size), 32'(m_size));
      chk("mem_sel", 32'(mem_sel), 32'(m_sel));
      chk("mem_a", mem_a, m_a);
      chk("mem_st_data", mem_st_data, m_wd);
      chk("inst_ready", 32'(inst_ready), 32'(e_ir));
      chk("data_ready", 32'(data_ready), 32'(e_dr));
      chk("inst_rdata", inst_rdata, m_ird);
      chk("data_rdata", data_rdata, m_drd);
      chk("stall_if", 32'(stall_if), 32'(inst_req & ~e_ir));
      chk("stall_mem", 32'(stall_mem), 32'(data_req & ~e_dr));
      chk("ready_overlap", 32'(inst_ready & data_ready), 32'd0);
    end
  end

  logic ir, dr;
  initial begin
    step;
    cmp_en = 1'b1;
    chk("rst_access", 32'(mem_access), 0);
    chk("rst_a", mem_a, 0);
    chk("rst_sel", 32'(mem_sel), 0);
    chk("rst_irdata", inst_rdata, 0);
    chk("rst_ready", 32'({inst_ready, data_ready}), 0);
    resetn = 1'b0;
    step;
    // fetch from kseg1 boot vector
    inst_req = 1; inst_addr = 32'hbfc0_0000;
    step;
    chk("fetch_access", 32'(mem_access), 1);
    chk("fetch_a", mem_a, 32'h1fc0_0000);
    chk("fetch_sel", 32'(mem_sel), 32'hf);
    chk("fetch_stall", 32'(stall_if), 1);
    step; step;
    mem_ready = 1; mem_data = 32'h2408_0001;
    step;
    mem_ready = 0;
    chk("fetch_ready", 32'(inst_ready), 1);
    chk("fetch_rdata", inst_rdata, 32'h2408_0001);
    chk("fetch_done_noacc", 32'(mem_access), 0);
    inst_req = 0;
    step;
    chk("fetch_pulse_end", 32'(inst_ready), 0);
    // contention: data wins
    inst_req = 1; inst_addr = 32'hbfc0_0010;
    data_req = 1; data_write = 0; data_size = 2'b10; data_wen = 4'hf; data_addr = 32'hbfaf_8000;
    step;
    chk("cont_first_a", mem_a, 32'h1faf_8000);
    mem_ready = 1; mem_data = 32'h1111_2222;
    step;
    mem_ready = 0;
    chk("cont_dready", 32'(data_ready), 1);
    chk("cont_iready_lo", 32'(inst_ready), 0);
    chk("cont_drdata", data_rdata, 32'h1111_2222);
    data_req = 0;
    step;
    chk("cont_idle_noacc", 32'(mem_access), 0);
    step;
    chk("cont_inst_a", mem_a, 32'h1fc0_0010);
    mem_ready = 1; mem_data = 32'h3333_4444;
    step;
    mem_ready = 0;
    chk("cont_iready", 32'(inst_ready), 1);
    chk("cont_dready_lo", 32'(data_ready), 0);
    inst_req = 0;
    step;
    // store
    data_req = 1; data_write = 1; data_wen = 4'b0011; data_size = 2'b01;
    data_wdata = 32'h0000_abcd; data_addr = 32'h8000_1000;
    step;
    chk("st_write", 32'(mem_write), 1);
    chk("st_sel", 32'(mem_sel), 32'h3);
    chk("st_a", mem_a, 32'h0000_1000);
    chk("st_data", mem_st_data, 32'h0000_abcd);
    chk("st_size", 32'(mem_size), 1);
    mem_ready = 1; mem_data = 32'hdead_beef;
    step;
    mem_ready = 0;
    chk("st_ready", 32'(data_ready), 1);
    chk("st_rdata_kept", data_rdata, 32'h1111_2222);
    data_req = 0; data_write = 0;
    step;
    // flush beats mem_ready
    inst_req = 1; inst_addr = 32'hbfc0_0020;
    step;
    mem_ready = 1; flush = 1; mem_data = 32'h5555_5555;
    step;
    mem_ready = 0; flush = 0;
    chk("fl_noready", 32'(inst_ready), 0);
    chk("fl_noacc", 32'(mem_access), 0);
    chk("fl_rdata_kept", inst_rdata, 32'h3333_4444);
    inst_req = 0;
    step;
    chk("fl_idle", 32'(mem_access), 0);
    // reset mid data access
    data_req = 1; data_write = 0; data_addr = 32'h0000_0100;
    step;
    chk("rs_access", 32'(mem_access), 1);
    #2 resetn = 1;
    #1;
    chk("rs_access0", 32'(mem_access), 0);
    chk("rs_a0", mem_a, 0);
    chk("rs_drdata0", data_rdata, 0);
    chk("rs_irdata0", inst_rdata, 0);
    data_req = 0; inst_req = 1; inst_addr = 32'hbfc0_0000;
    step;
    resetn = 0;
    step;
    chk("rs_regrant", 32'(mem_access), 1);
    chk("rs_regrant_a", mem_a, 32'h1fc0_0000);
    // back-to-back fetches with request held
    mem_ready = 1; mem_data = 32'h0bad_f00d;
    step;
    mem_ready = 0;
    chk("b2b_ready", 32'(inst_ready), 1);
    chk("b2b_done_noacc", 32'(mem_access), 0);
    step;
    chk("b2b_idle_noacc", 32'(mem_access), 0);
    step;
    chk("b2b_regrant", 32'(mem_access), 1);
    mem_ready = 1;
    step;
    mem_ready = 0; inst_req = 0;
    step;
    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      step;
      ir = inst_ready; dr = data_ready;
      resetn = ($urandom % 300) == 0;
      if (!inst_req || ir) begin
        inst_req = ($urandom % 3) == 0;
        inst_addr = $urandom;
      end else if (($urandom % 40) == 0) inst_req = 0;
      if (!data_req || dr) begin
        data_req = ($urandom % 3) == 0;
        data_addr = $urandom; data_write = $urandom; data_size = 2'($urandom);
        data_wen = 4'($urandom); data_wdata = $urandom;
      end else if (($urandom % 40) == 0) data_req = 0;
      mem_ready = ($urandom % 3) == 0;
      mem_data = $urandom;
      flush = ($urandom % 25) == 0;
    end
    step;
    resetn = 0; inst_req = 0; data_req = 0; flush = 0; mem_ready = 0;
    repeat (4) step;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
